// File: rtl/ahb_bus_arbiter.sv
// AHB-lite bus arbiter for NUM_MASTERS masters sharing one slave port.
// Tracks the address-phase owner and the data-phase owner separately, so the
// write data and responses of a handed-over transfer still reach the right master.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
//
//   state  | meaning
//   -------+---------------------------------------------
//   PARKED | nobody requested; bus parked on PARK_MASTER
//   OWNED  | owner holds the bus, may be rearbitrated
//   LOCKED | owner asserts m_lock_i; bus held until it drops
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int PARK_MASTER = 0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_lock_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_haddr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata_i,
  input  logic [NUM_MASTERS*3-1:0]          m_hsize_i,
  input  logic [NUM_MASTERS*2-1:0]          m_htrans_i,
  input  logic [NUM_MASTERS-1:0]            m_hwrite_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_hready_o,
  output logic [NUM_MASTERS*2-1:0]          m_hresp_o,
  output logic [DATA_WIDTH-1:0]             m_hrdata_o,
  output logic [DATA_WIDTH-1:0]             haddr_o,
  output logic [DATA_WIDTH-1:0]             hwdata_o,
  output logic [2:0]                        hsize_o,
  output logic [1:0]                        htrans_o,
  output logic                              hwrite_o,
  input  logic [DATA_WIDTH-1:0]             hrdata_i,
  input  logic                              hready_i,
  input  logic [1:0]                        hresp_i,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner_o
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam logic [OW-1:0] PARK = OW'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {PARKED, OWNED, LOCKED} state_t;

  state_t          state;
  logic [OW-1:0]   addr_owner;
  logic [OW-1:0]   data_owner;
  logic            data_valid;
  logic [OW-1:0]   winner;
  logic            any_req;
  logic            owner_lock;
  logic [1:0]      owner_trans;
  logic            rearb;

  assign owner_lock  = m_lock_i[addr_owner];
  assign owner_trans = m_htrans_i[int'(addr_owner)*2 +: 2];
  // Never split a burst (SEQ) and never take the bus from a locked owner.
  assign rearb       = hready_i && !owner_lock && (owner_trans != 2'b11);
  assign any_req     = |m_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic [OW-1:0] rr_ptr;
  int            idx;
  logic          found;

  // Round-robin pick: first requester at or after the pointer.
  always_comb begin
    winner = PARK;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_MASTERS;
      if (!found && m_req_i[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Pointer moves past the winner on every granting rearbitration.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
    end else if (rearb && any_req) begin
      rr_ptr <= (int'(winner) == NUM_MASTERS-1) ? '0 : winner + 1'b1;
    end
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    winner = PARK;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (m_req_i[k]) winner = OW'(k);
    end
  end
`endif

  // Ownership FSM with registered grant; data phase follows address phase on hready.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= PARKED;
      addr_owner <= PARK;
      data_owner <= PARK;
      data_valid <= 1'b0;
      m_gnt_o    <= ONE << PARK;
    end else begin
      if (hready_i) begin
        data_owner <= addr_owner;
        data_valid <= owner_trans[1];
      end
      if (rearb) begin
        if (any_req) begin
          addr_owner <= winner;
          m_gnt_o    <= ONE << winner;
          state      <= m_lock_i[winner] ? LOCKED : OWNED;
        end else begin
          addr_owner <= PARK;
          m_gnt_o    <= ONE << PARK;
          state      <= PARKED;
        end
      end else if (state == LOCKED && !owner_lock) begin
        state <= OWNED;
      end else if (state != LOCKED && owner_lock) begin
        state <= LOCKED;
      end
    end
  end

  // Per-master ready and response routing.
  always_comb begin
    m_hready_o = '0;
    m_hresp_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (int'(addr_owner) == i || (data_valid && int'(data_owner) == i))
        m_hready_o[i] = hready_i;
      if (data_valid && int'(data_owner) == i)
        m_hresp_o[i*2 +: 2] = hresp_i;
    end
  end

  assign haddr_o    = m_haddr_i[int'(addr_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign hsize_o    = m_hsize_i[int'(addr_owner)*3 +: 3];
  assign htrans_o   = owner_trans;
  assign hwrite_o   = m_hwrite_i[addr_owner];
  assign hwdata_o   = m_hwdata_i[int'(data_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign m_hrdata_o = hrdata_i;
  assign owner_o    = addr_owner;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Testbench for ahb_bus_arbiter with four masters: directed scenarios then
// randomized traffic, all checked against a transaction-level ownership model.
module tb_ahb_bus_arbiter;

  localparam int NM   = 4;
  localparam int DW   = 32;
  localparam int PARK = 0;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   req, lock, hwrite_m;
  logic [NM*DW-1:0] haddr_m, hwdata_m;
  logic [NM*3-1:0] hsize_m;
  logic [NM*2-1:0] htrans_m;
  logic [NM-1:0]   gnt, hready_m;
  logic [NM*2-1:0] hresp_m;
  logic [DW-1:0]   hrdata_m, haddr, hwdata, hrdata;
  logic [2:0]      hsize;
  logic [1:0]      htrans, hresp;
  logic            hwrite, hready;
  logic [1:0]      owner;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mo, mdo, mptr;
  bit mdv;

  ahb_bus_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .PARK_MASTER(PARK)) dut (
    .clk_i(clk), .reset_i(rst),
    .m_req_i(req), .m_lock_i(lock),
    .m_haddr_i(haddr_m), .m_hwdata_i(hwdata_m),
    .m_hsize_i(hsize_m), .m_htrans_i(htrans_m), .m_hwrite_i(hwrite_m),
    .m_gnt_o(gnt), .m_hready_o(hready_m), .m_hresp_o(hresp_m), .m_hrdata_o(hrdata_m),
    .haddr_o(haddr), .hwdata_o(hwdata), .hsize_o(hsize), .htrans_o(htrans), .hwrite_o(hwrite),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp),
    .owner_o(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner among requesters: smallest forward distance from the pointer (round robin)
  // or lowest set bit (fixed priority).
  function automatic int pick(input logic [NM-1:0] r, input int p);
`ifdef ARB_ROUND_ROBIN_EN
    int best  = -1;
    int bestd = NM;
    for (int i = 0; i < NM; i++) begin
      if (r[i] && ((i - p + NM) % NM) < bestd) begin
        bestd = (i - p + NM) % NM;
        best  = i;
      end
    end
    return best;
`else
    logic [NM-1:0] low;
    low = r & (~r + 1'b1);
    return $clog2(low);
`endif
  endfunction

  task automatic model_check();
    logic [NM-1:0]   eg, er;
    logic [NM*2-1:0] ep;
    eg = '0; eg[mo] = 1'b1;
    er = '0; ep = '0;
    er[mo] = hready;
    if (mdv) begin
      er[mdo] = hready;
      ep[mdo*2 +: 2] = hresp;
    end
    chk("gnt", gnt, eg);
    chk("onehot", $onehot(gnt), 1);
    chk("owner", owner, mo);
    chk("hready_m", hready_m, er);
    chk("hresp_m", hresp_m, ep);
    chk("haddr", haddr, haddr_m[mo*DW +: DW]);
    chk("hsize", hsize, hsize_m[mo*3 +: 3]);
    chk("htrans", htrans, htrans_m[mo*2 +: 2]);
    chk("hwrite", hwrite, hwrite_m[mo]);
    chk("hwdata", hwdata, hwdata_m[mdo*DW +: DW]);
    chk("hrdata", hrdata_m, hrdata);
  endtask

  task automatic model_update();
    int  t;
    if (rst) begin
      mo = PARK; mdo = PARK; mdv = 0; mptr = 0;
    end else begin
      t = int'(htrans_m[mo*2 +: 2]);
      if (hready) begin
        mdo = mo;
        mdv = (t == 2 || t == 3);
      end
      if (hready && !lock[mo] && t != 3) begin
        if (req != '0) begin
          mo   = pick(req, mptr);
          mptr = (mo + 1) % NM;
        end else begin
          mo = PARK;
        end
      end
    end
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [1:0] tr [4];
    tr[0] = 2'b00; tr[1] = 2'b10; tr[2] = 2'b11; tr[3] = 2'b01;
    req    = NM'($urandom);
    lock   = '0;
    for (int i = 0; i < NM; i++) begin
      lock[i] = ($urandom_range(0, 7) == 0);
      htrans_m[i*2 +: 2] = tr[$urandom_range(0, 3)];
      hsize_m[i*3 +: 3]  = 3'($urandom);
      haddr_m[i*DW +: DW]  = $urandom;
      hwdata_m[i*DW +: DW] = $urandom;
    end
    hwrite_m = NM'($urandom);
    hready   = ($urandom_range(0, 3) != 0);
    hresp    = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
    hrdata   = $urandom;
    rst      = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    logic [NM-1:0] rr_seq [5];
`ifdef ARB_ROUND_ROBIN_EN
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    mo = PARK; mdo = PARK; mdv = 0; mptr = 0;
    rst = 1'b1; req = '0; lock = '0; hwrite_m = '0; hsize_m = '0; htrans_m = '0;
    hready = 1'b1; hresp = 2'b00; hrdata = 32'hCAFE_0001;
    for (int i = 0; i < NM; i++) begin
      haddr_m[i*DW +: DW]  = 32'hA000_0000 + i;
      hwdata_m[i*DW +: DW] = 32'hD000_0000 + i;
    end
    @(negedge clk);
    @(posedge clk); model_update(); @(negedge clk);
    @(posedge clk); model_update(); @(negedge clk);

    // reset release, idle bus stays parked
    rst = 1'b0;
    chk("rst_gnt", gnt, 4'b0001);
    chk("rst_hresp", hresp_m, 8'h00);
    chk("rst_hready", hready_m, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("park_gnt", gnt, 4'b0001);
      chk("park_owner", owner, 0);
    end

    // locked owner keeps the bus
    req = 4'b0010; lock = 4'b0010;
    cycle();
    chk("lock_gnt", gnt, 4'b0010);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lock_hold", gnt, 4'b0010);
    end
    req = 4'b0000; lock = 4'b0000;
    cycle();
    chk("unlock_park", gnt, 4'b0001);

    // burst is not split; handover keeps write data with the data-phase owner
    req = 4'b0001; htrans_m[1:0] = 2'b10;
    cycle();
    chk("burst_start", gnt, 4'b0001);
    req = 4'b0011; htrans_m[1:0] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("burst_hold", gnt, 4'b0001);
    end
    req = 4'b0010; htrans_m[1:0] = 2'b10; htrans_m[3:2] = 2'b10;
    cycle();
    chk("handover_gnt", gnt, 4'b0010);
    chk("handover_haddr", haddr, 32'hA000_0001);
    chk("handover_hwdata", hwdata, 32'hD000_0000);

    // slave stall at the handover, error response routed to data owner only
    req = 4'b0001; hready = 1'b0; hresp = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hresp", hresp_m, 8'b0000_0001);
      chk("stall_hwdata", hwdata, 32'hD000_0000);
      cycle();
      chk("stall_gnt", gnt, 4'b0010);
    end
    hready = 1'b1;
    cycle();
    chk("err_keep_then_switch", gnt, 4'b0001);
    chk("after_stall_hwdata", hwdata, 32'hD000_0001);
    hresp = 2'b00;

    // all masters requesting: rotation or fixed priority
    rst = 1'b1; req = '0; htrans_m = '0;
    cycle();
    rst = 1'b0; req = 4'b1111; htrans_m = 8'b1010_1010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("all_req_gnt", gnt, rr_seq[i]);
    end

    // reset during a locked owner
    req = 4'b0010; lock = 4'b0010; htrans_m = '0;
    cycle();
    cycle();
    chk("pre_rst_lock", gnt, 4'b0010);
    rst = 1'b1; hresp = 2'b01; htrans_m = 8'b0000_1000;
    cycle();
    chk("rst_lock_gnt", gnt, 4'b0001);
    chk("rst_lock_hresp", hresp_m, 8'h00);
    chk("rst_lock_hready", hready_m, 4'b0001);
    rst = 1'b0; req = '0; lock = '0; hresp = 2'b00; htrans_m = '0;
    cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of AHB-lite masters (legal 2..8; master 0 = scalar core).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, address and data width.
REQ-003 SHALL have parameter PARK_MASTER, default 0, master that owns the bus when nobody requests.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; ports clk_i and reset_i are listed below.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 reset_i  input  1  synchronous active-high reset.
REQ-007 m_req_i  input  NUM_MASTERS  per-master bus request.
REQ-008 m_lock_i  input  NUM_MASTERS  per-master hold request, e.g. vector LSU active.
REQ-009 m_haddr_i / m_hwdata_i  input  NUM_MASTERS*DATA_WIDTH  packed address and write data, master i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 m_hsize_i  input  NUM_MASTERS*3  packed HSIZE.
REQ-011 m_htrans_i  input  NUM_MASTERS*2  packed HTRANS: 00 IDLE, 10 NONSEQ, 11 SEQ.
REQ-012 m_hwrite_i  input  NUM_MASTERS  per-master HWRITE.
REQ-013 m_gnt_o  output  NUM_MASTERS  one-hot address-phase grant.
REQ-014 m_hready_o  output  NUM_MASTERS  per-master HREADY.
REQ-015 m_hresp_o  output  NUM_MASTERS*2  per-master HRESP.
REQ-016 m_hrdata_o  output  DATA_WIDTH  read data, broadcast to all masters.
REQ-017 haddr_o, hwdata_o  output  DATA_WIDTH  each; hsize_o  output  3; htrans_o  output  2; hwrite_o  output  1; all are slave-side AHB signals.
REQ-018 hrdata_i  input  DATA_WIDTH; hready_i  input  1; hresp_i  input  2; all are slave-side responses.
REQ-019 owner_o  output  $clog2(NUM_MASTERS)  current address-phase owner index.

Function
REQ-020 SHALL hold addr_owner (address-phase owner) and data_owner plus data_valid (data-phase owner).
REQ-021 SHALL drive haddr_o, hsize_o, htrans_o and hwrite_o combinationally from addr_owner, and hwdata_o from data_owner.
REQ-022 On each edge with hready_i=1: data_owner <= addr_owner; data_valid <= 1 if addr_owner's htrans is NONSEQ or SEQ, else 0.
REQ-023 With hready_i=0, data_owner and data_valid SHALL hold their values.
REQ-024 m_hready_o[i] = hready_i when i==addr_owner or (data_valid and i==data_owner); otherwise it SHALL be 0.
REQ-025 m_hresp_o[i] = hresp_i when data_valid and i==data_owner; otherwise it SHALL be 00.
REQ-026 FSM states:
- PARKED: no request; addr_owner=PARK_MASTER.
- OWNED: owner requesting, unlocked.
- LOCKED: owner has m_lock_i=1.
REQ-027 Rearbitration SHALL happen only on an edge where all of the following hold: hready_i=1; the owner's m_lock_i=0; the owner's htrans is not SEQ, so bursts are never split.
REQ-028 At rearbitration, when any m_req_i is set, addr_owner <= the winner per REQ-040/041; with no request, addr_owner <= PARK_MASTER and the FSM goes to PARKED.
REQ-029 Grant latency SHALL be exactly 1 cycle: a request sampled at edge t with rearbitration allowed gives m_gnt_o high after edge t.
REQ-030 A locked owner SHALL keep the bus regardless of its own m_req_i; when lock drops, the FSM goes LOCKED->OWNED in the same edge and rearbitration follows normally.
REQ-031 When the current owner also wins, grant SHALL be unchanged with no bubble.
REQ-032 An ERROR response (hresp_i=01) SHALL NOT change ownership.
REQ-033 m_gnt_o SHALL be exactly one-hot in every cycle.

Reset
REQ-034 While reset_i=1 at an edge, the block SHALL set addr_owner=PARK_MASTER, data_owner=PARK_MASTER, data_valid=0, FSM=PARKED and the round-robin pointer=0.
REQ-035 Reset SHALL take priority over any transfer in progress, including mid-burst and LOCKED.
REQ-036 After reset: m_gnt_o=one-hot(PARK_MASTER); m_hresp_o all 0; m_hready_o[PARK_MASTER]=hready_i and all others 0.

Configuration
REQ-040 With ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requester at or after pointer, modulo NUM_MASTERS, and the pointer SHALL become winner+1 (wrapping to 0) at each rearbitration that grants.
REQ-041 Without ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority (lowest index wins), the pointer logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-050 Reset with hready_i=1, no requests -> m_gnt_o=01 (NUM_MASTERS=2) and owner_o=0 held for 10 cycles.
REQ-051 Master 1 raises req and lock; master 0 is IDLE -> m_gnt_o=10 one cycle later; master 0 req ignored while lock=1; after lock and req drop -> m_gnt_o=01 next edge.
REQ-052 Master 0 mid-burst (SEQ) while master 1 requests -> no switch until master 0 issues NONSEQ/IDLE with hready_i=1; hwdata_o tracks data_owner across the handover cycle.
REQ-053 Hold hready_i=0 for 3 cycles at a handover -> addr_owner, data_owner and the stalled master's hresp routing stay unchanged; hresp_i=01 goes only to data_owner.
REQ-054 NUM_MASTERS=4 with ARB_ROUND_ROBIN_EN, all requesting, no locks -> grants 0,1,2,3,0 on successive rearbitrations; without the macro -> grant stays 0.
REQ-055 Assert reset_i during LOCKED owner 1 -> next cycle m_gnt_o=one-hot(0), data_valid=0, m_hresp_o=0.
